dmem_stage: RTL and testbench

- Memory-stage access controller. It sits directly downstream of the pipeline datapath's ALU register.
- Consumes ALUOutM, WriteDataM and the M-stage memory controls, and drives a variable-latency backing data memory over a req/ack handshake.
- Returns the full 32-bit ReadData word to the read-data register. That register performs byte selection on load.
- Asserts StallM to freeze the pipeline while an access is outstanding.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_byte_lane.sv | 32 +++
 rtl/dmem_stage.sv | 138 +++++++++++++
 tb/tb_dmem_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the memory-stage controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Big-endian lane order: byte 0 of the word lives on the MSB lane.
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_B0   = 4'b1000;
    localparam logic [3:0] BE_B1   = 4'b0100;
    localparam logic [3:0] BE_B2   = 4'b0010;
    localparam logic [3:0] BE_B3   = 4'b0001;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/dmem_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : dmem_byte_lane
// Description : Byte-enable decode and store-data lane replication.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_byte_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic        i_byte,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        if (i_byte) begin
            o_wdata = {4{i_wdata[7:0]}};
            case (i_addr_lo)
                2'd0:    o_be = BE_B0;
                2'd1:    o_be = BE_B1;
                2'd2:    o_be = BE_B2;
                default: o_be = BE_B3;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_stage.sv
`default_nettype none
// ============================================================================
// Module      : dmem_stage
// Description : M-stage access controller driving a req/ack data memory.
//               Optional one-entry posted-write buffer: DMEM_STORE_BUFFER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_stage
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic              ByteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadData,
    output logic              StallM,
    output logic              MemErrM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_access;
    logic               w_timeout;
    logic               w_drain;
    logic               w_post;
    logic [3:0]         w_be;
    logic [DATA_W-1:0]  w_wdata;

    assign w_access  = MemReadM | MemWriteM;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    dmem_byte_lane u_byte_lane (
        .i_addr_lo (ALUOutM[1:0]),
        .i_byte    (ByteM),
        .i_wdata   (WriteDataM),
        .o_be      (w_be),
        .o_wdata   (w_wdata)
    );

`ifdef DMEM_STORE_BUFFER_EN
    // Set while the in-flight access is a posted store the pipeline has left.
    logic r_drain;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drain <= 1'b0;
        end else if (r_state == IDLE && w_access) begin
            r_drain <= MemWriteM;
        end else if (r_state == REQ && (mem_ack || w_timeout)) begin
            r_drain <= 1'b0;
        end
    end

    assign w_drain = r_drain;
    assign w_post  = MemWriteM;
`else
    assign w_drain = 1'b0;
    assign w_post  = 1'b0;
`endif

    always_comb begin
        StallM = 1'b0;
        case (r_state)
            IDLE:    StallM = w_access & ~w_post;
            REQ:     StallM = w_drain ? w_access : 1'b1;
            default: StallM = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            ReadData  <= '0;
            MemErrM   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
        end else begin
            MemErrM <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_access) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;
                        mem_addr  <= {ALUOutM[ADDR_W-1:2], 2'b00};
                        mem_wdata <= w_wdata;
                        mem_be    <= w_be;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ReadData <= mem_rdata;
                        end
                        r_state <= w_drain ? IDLE : DONE;
                    end else if (w_timeout) begin
                        mem_req <= 1'b0;
                        MemErrM <= 1'b1;
                        if (!mem_we) begin
                            ReadData <= '0;
                        end
                        r_state <= w_drain ? IDLE : DONE;
                    end
                end
                DONE: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_stage
// Description : Scoreboard bench for dmem_stage with a latency-programmable memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_stage;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        ByteM = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadData;
    logic        StallM;
    logic        MemErrM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ByteM      (ByteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadData   (ReadData),
        .StallM     (StallM),
        .MemErrM    (MemErrM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        int          stall;
        logic [31:0] rdata;
        logic        err;
    } cpl_t;

    req_t req_q[$];
    cpl_t cpl_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int err_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: acks on the ack_lat-th REQ cycle; ack_lat of 0 never acks.
    int          ack_lat = 1;
    int          req_cyc = 0;
    logic [31:0] rdata_val = '0;
    bit          mem_auto = 1'b1;

    always @(negedge clk) begin
        if (mem_auto) begin
            if (mem_req === 1'b1) begin
                req_cyc++;
                mem_ack = (ack_lat != 0) && (req_cyc == ack_lat);
            end else begin
                req_cyc = 0;
                mem_ack = 1'b0;
            end
            mem_rdata = rdata_val;
        end
    end

    // Monitor: bus launch on each mem_req rise; completion on each stall release.
    int   stall_cnt = 0;
    logic prev_req = 1'b0;
    req_t m_r;
    cpl_t m_c;

    always @(negedge clk) begin
        if (MemErrM === 1'b1) err_total++;
        if (mem_req === 1'b1 && prev_req !== 1'b1) begin
            if (req_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
            end else begin
                m_r = req_q.pop_front();
                chk("mem_we",    {31'd0, mem_we}, {31'd0, m_r.we});
                chk("mem_addr",  mem_addr, m_r.addr);
                chk("mem_wdata", mem_wdata, m_r.wdata);
                chk("mem_be",    {28'd0, mem_be}, {28'd0, m_r.be});
            end
        end
        prev_req = mem_req;
        if (StallM === 1'b1) begin
            stall_cnt++;
        end else if (stall_cnt > 0) begin
            if (cpl_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_release: got stall %0d expected none", stall_cnt);
            end else begin
                m_c = cpl_q.pop_front();
                chk("stall_cycles", stall_cnt, m_c.stall);
                chk("ReadData",     ReadData, m_c.rdata);
                chk("MemErrM",      {31'd0, MemErrM}, {31'd0, m_c.err});
            end
            stall_cnt = 0;
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic byt,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int lat, input logic [31:0] rdv,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [3:0] e_be, input int e_stall,
                         input logic [31:0] e_rdata, input logic e_err);
        req_t r;
        cpl_t c;
        bit   done;
        r.we = wr; r.addr = e_addr; r.wdata = e_wdata; r.be = e_be;
        req_q.push_back(r);
        if (e_stall > 0) begin
            c.stall = e_stall; c.rdata = e_rdata; c.err = e_err;
            cpl_q.push_back(c);
        end
        ack_lat = lat;
        rdata_val = rdv;
        MemReadM = rd; MemWriteM = wr; ByteM = byt; ALUOutM = addr; WriteDataM = wd;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (StallM === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL stall_timeout: got StallM stuck at addr %h expected release", addr);
        end
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ReadData",  ReadData, 32'h0);
        chk("rst_mem_req",   {31'd0, mem_req}, 32'h0);
        chk("rst_mem_we",    {31'd0, mem_we}, 32'h0);
        chk("rst_mem_addr",  mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_be",    {28'd0, mem_be}, 32'h0);
        chk("rst_MemErrM",   {31'd0, MemErrM}, 32'h0);
        chk("rst_StallM",    {31'd0, StallM}, 32'h0);

        //     rd   wr   byte addr          wdata          lat rdata          e_addr         e_wdata        e_be     stall e_rdata        err
        issue(1'b1,1'b0,1'b0,32'h0000_0100,32'h0,        1, 32'hDEAD_BEEF,32'h0000_0100,32'h0,        4'b1111, 2, 32'hDEAD_BEEF,1'b0);
`ifndef DMEM_STORE_BUFFER_EN
        issue(1'b0,1'b1,1'b1,32'h0000_0203,32'h1234_56A5,3, 32'h7777_7777,32'h0000_0200,32'hA5A5_A5A5,4'b0001, 4, 32'hDEAD_BEEF,1'b0);
`endif
        issue(1'b1,1'b0,1'b0,32'h0000_0040,32'h0,        0, 32'h5555_5555,32'h0000_0040,32'h0,        4'b1111, 9, 32'h0,        1'b1);
        issue(1'b1,1'b0,1'b1,32'h0000_0301,32'h0,        2, 32'hCAFE_F00D,32'h0000_0300,32'h0,        4'b0100, 3, 32'hCAFE_F00D,1'b0);

        // Reset lands in the REQ cycle of a load; the late ack must be ignored.
        begin
            req_t r;
            cpl_t c;
            r.we = 1'b0; r.addr = 32'h0000_0044; r.wdata = 32'h0; r.be = 4'b1111;
            req_q.push_back(r);
            c.stall = 2; c.rdata = 32'h0; c.err = 1'b0;
            cpl_q.push_back(c);
            mem_auto = 1'b0;
            mem_ack = 1'b0;
            MemReadM = 1'b1; ByteM = 1'b0; ALUOutM = 32'h0000_0044; WriteDataM = 32'h0;
            @(posedge clk); #1;
            reset = 1'b1; MemReadM = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
            chk("midrst_mem_req",  {31'd0, mem_req}, 32'h0);
            chk("midrst_mem_addr", mem_addr, 32'h0);
            chk("midrst_mem_be",   {28'd0, mem_be}, 32'h0);
            chk("midrst_ReadData", ReadData, 32'h0);
            chk("midrst_StallM",   {31'd0, StallM}, 32'h0);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            chk("lateack_ReadData", ReadData, 32'h0);
            chk("lateack_mem_req",  {31'd0, mem_req}, 32'h0);
            chk("lateack_MemErrM",  {31'd0, MemErrM}, 32'h0);
            mem_auto = 1'b1;
        end

        issue(1'b1,1'b0,1'b0,32'h0000_0014,32'h0,        1, 32'h0BAD_C0DE,32'h0000_0014,32'h0,        4'b1111, 2, 32'h0BAD_C0DE,1'b0);
`ifndef DMEM_STORE_BUFFER_EN
        issue(1'b1,1'b1,1'b0,32'h0000_0010,32'h55AA_1234,1, 32'h6666_6666,32'h0000_0010,32'h55AA_1234,4'b1111, 2, 32'h0BAD_C0DE,1'b0);
        issue(1'b0,1'b1,1'b0,32'h0000_0020,32'h0102_0304,0, 32'h0,        32'h0000_0020,32'h0102_0304,4'b1111, 9, 32'h0BAD_C0DE,1'b1);
        issue(1'b0,1'b1,1'b1,32'h0000_0500,32'hFFFF_FF3C,1, 32'h1212_1212,32'h0000_0500,32'h3C3C_3C3C,4'b1000, 2, 32'h0BAD_C0DE,1'b0);
        issue(1'b0,1'b1,1'b1,32'h0000_0501,32'hFFFF_FF3C,1, 32'h1212_1212,32'h0000_0500,32'h3C3C_3C3C,4'b0100, 2, 32'h0BAD_C0DE,1'b0);
        issue(1'b0,1'b1,1'b1,32'h0000_0502,32'hFFFF_FF3C,1, 32'h1212_1212,32'h0000_0500,32'h3C3C_3C3C,4'b0010, 2, 32'h0BAD_C0DE,1'b0);
        issue(1'b0,1'b1,1'b1,32'h0000_0503,32'hFFFF_FF3C,1, 32'h1212_1212,32'h0000_0500,32'h3C3C_3C3C,4'b0001, 2, 32'h0BAD_C0DE,1'b0);
`endif
        issue(1'b1,1'b0,1'b0,32'h0000_0107,32'h0,        2, 32'h1357_9BDF,32'h0000_0104,32'h0,        4'b1111, 3, 32'h1357_9BDF,1'b0);
`ifdef DMEM_STORE_BUFFER_EN
        // Posted store: no stall; the following load waits out the drain.
        issue(1'b0,1'b1,1'b0,32'h0000_0080,32'h1122_3344,1, 32'h0,        32'h0000_0080,32'h1122_3344,4'b1111, 0, 32'h0,        1'b0);
        issue(1'b1,1'b0,1'b0,32'h0000_0080,32'h0,        1, 32'h1122_3344,32'h0000_0080,32'h0,        4'b1111, 3, 32'h1122_3344,1'b0);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("req_queue_drained", req_q.size(), 32'd0);
        chk("cpl_queue_drained", cpl_q.size(), 32'd0);
`ifdef DMEM_STORE_BUFFER_EN
        chk("MemErrM_pulses", err_total, 32'd1);
`else
        chk("MemErrM_pulses", err_total, 32'd2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected $finish");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
